ahb_mem_slave: RTL and testbench
================================

Name: ahb_mem_slave

Overview:
- Synthesizable AHB slave memory that sits directly downstream of the AHB master BFM.
- Consumes the master's address/control/write-data phases and returns HRDATA/HREADYOUT/HRESP.
- Supports 1/2/4-byte single transfers and SEQ bursts, with programmable wait states and ERROR response for illegal accesses.
- Used as the reference AHB target when the bridge path is bypassed, and as a second slave on the decoded bus.

Parameters:
- START_ADDR, 32'h0, first byte address decoded by this slave.
- DEPTH_IN_BYTES, 32'h400, memory size; multiple of 4, power of two, max 64KB.
- WAIT_CYCLES, 0, wait states inserted per data beat (0..15).

Ports:
- HCLK  input  1  bus clock; all logic on rising edge.
- HRESETn  input  1  synchronous active-low reset.
- HSEL  input  1  slave select from decoder.
- HADDR  input  32  byte address.
- HTRANS  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE  input  1  1=write.
- HSIZE  input  3  0=byte, 1=half, 2=word; others illegal.
- HBURST  input  3  burst type; informational only, not checked.
- HWDATA  input  32  write data, valid in data phase.
- HREADY  input  1  bus-level ready (previous transfer complete).
- HREADYOUT  output  1  slave ready.
- HRESP  output  2  OKAY=2'b00, ERROR=2'b01; RETRY/SPLIT never driven.
- HRDATA  output  32  read data.

Behaviour:
- Reset is synchronous: HRESETn sampled low at a rising HCLK edge forces:
  - FSM to ST_IDLE;
  - HREADYOUT=1, HRESP=OKAY, HRDATA=0;
  - wait counter=0 and pending-transfer registers cleared.
- Memory array is not reset; contents survive reset.
- Accept condition: HSEL & HREADY & HTRANS[1] (NONSEQ/SEQ). On an accept edge, register address, write, size and a legal flag.
- Legal flag requires all of:
  - (HADDR-START_ADDR) < DEPTH_IN_BYTES (unsigned);
  - HSIZE <= 2;
  - HADDR aligned to size: half needs HADDR[0]=0, word needs HADDR[1:0]=0.
- IDLE or BUSY transfers, or HSEL=0: no state change; zero-wait OKAY response.
- FSM states:
  - ST_IDLE: HREADYOUT=1, OKAY. Legal accept goes to ST_WAIT if WAIT_CYCLES>0, else ST_DATA. Illegal accept goes to ST_ERR1.
  - ST_WAIT: HREADYOUT=0. Counter loads WAIT_CYCLES-1 on entry and decrements each cycle; at 0 go to ST_DATA. Accepts are blocked because HREADY is low.
  - ST_DATA: HREADYOUT=1, OKAY; the beat completes this cycle. A simultaneous accept is evaluated exactly as in ST_IDLE (pipelined back-to-back); with no accept, go to ST_IDLE.
  - ST_ERR1: HREADYOUT=0, HRESP=ERROR. Always goes to ST_ERR2.
  - ST_ERR2: HREADYOUT=1, HRESP=ERROR. Accepts are evaluated as in ST_IDLE; a master that cancels with IDLE simply returns to ST_IDLE.
- Write commit:
  - Happens at the ST_DATA completing edge, using HWDATA sampled that cycle.
  - Little-endian byte lanes from size and address[1:0]:
    - byte: lane = addr[1:0];
    - half: lanes {addr[1],0} and {addr[1],1};
    - word: all four lanes.
  - Non-selected bytes are unchanged. Illegal transfers never write.
- Read data:
  - In ST_DATA for a read, HRDATA = full 32-bit word at the registered word address, all lanes unmasked; the master aligns.
  - Otherwise HRDATA=0.
  - A read issued directly after a write to the same word returns the new data; no stale forwarding is allowed.
- Latency: data phase completes WAIT_CYCLES+1 cycles after the address-phase accept edge.
- Back-to-back bursts with WAIT_CYCLES=0 sustain one beat per cycle.
- Reset mid-WAIT or mid-ERR: pending transfer is dropped and no write is committed.

Decomposition:
- Package ahb_mem_pkg holds:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ;
  - HRESP encodings OKAY/ERROR;
  - HSIZE encodings;
  - FSM state enum (ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2).
- One sub-module: ahb_mem_bytelane_ram, a word-wide array with a 4-bit byte-enable write port and a combinational read port.
- Byte-enable generation lives in the top.

Test Plan:
- WAIT_CYCLES=0, START_ADDR=0: write word 32'hDEADBEEF @0x10, then read @0x10 → HRDATA=32'hDEADBEEF, HREADYOUT never low, HRESP=OKAY.
- Byte write 8'hA5 @0x13 over word 32'h11223344 @0x10 → read word returns 32'hA5223344. Half write 16'h7777 @0x10 → read returns 32'hA5227777.
- WAIT_CYCLES=3: single read → HREADYOUT low exactly 3 cycles, then high with data. INCR4 write then INCR4 read @0x40 → 4 beats, each preceded by 3 wait cycles, data matches.
- WAIT_CYCLES=0, back-to-back NONSEQ+3×SEQ INCR4 write then INCR4 read → 4 consecutive HREADYOUT=1 data beats per burst, no bubbles, read data matches write data.
- Access @START_ADDR+DEPTH_IN_BYTES, HSIZE=3, or half write @0x1 → HREADYOUT=0/HRESP=ERROR one cycle, then HREADYOUT=1/HRESP=ERROR, then OKAY. Memory is unchanged on readback.
- Assert HRESETn=0 during the ST_WAIT of a write → next edge gives HREADYOUT=1, OKAY, HRDATA=0, and the target word keeps its old value. HSEL=0 with HTRANS=NONSEQ → no response change, no write.

Source files
------------

// File: rtl/ahb_mem_pkg.sv
// Shared encodings and helpers for the AHB memory slave.
package ahb_mem_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      HRESP_OKAY  = 2'b00,
      HRESP_ERROR = 2'b01
   } hresp_e;

   typedef enum logic [2:0] {
      HSIZE_BYTE = 3'd0,
      HSIZE_HALF = 3'd1,
      HSIZE_WORD = 3'd2
   } hsize_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_e;

   // HREADYOUT value presented while sitting in a given state.
   function automatic logic state_ready(input state_e s);
      return !((s == ST_WAIT) || (s == ST_ERR1));
   endfunction

   // HRESP value presented while sitting in a given state.
   function automatic logic [1:0] state_resp(input state_e s);
      return ((s == ST_ERR1) || (s == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
   endfunction

   // Natural alignment check; sizes above a word never pass.
   function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] addr);
      logic ok;
      case (size)
         HSIZE_BYTE: ok = 1'b1;
         HSIZE_HALF: ok = (addr[0] == 1'b0);
         HSIZE_WORD: ok = (addr == 2'b00);
         default:    ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/ahb_mem_bytelane_ram.sv
// Word-wide storage with per-byte write enables and an asynchronous read port.
// Contents are deliberately not reset.
module ahb_mem_bytelane_ram #(
   parameter int unsigned Words = 256,
   parameter int unsigned AddrW = 8
) (
   input  logic             clk_i,
   input  logic [3:0]       we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [31:0]      wdata_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [31:0]      rdata_o
);

   logic [31:0] mem_q [Words];

   // Byte-lane write: only enabled lanes of the addressed word change.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < 4; b++) begin
         if (we_i[b]) begin
            mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: byte/half/word singles and bursts, programmable wait
// states, two-cycle ERROR response for out-of-range, oversize or misaligned
// accesses.
module ahb_mem_slave
   import ahb_mem_pkg::*;
#(
   parameter logic [31:0] START_ADDR     = 32'h0,
   parameter int unsigned DEPTH_IN_BYTES = 32'h400,
   parameter int unsigned WAIT_CYCLES    = 0
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic [1:0]  HRESP,
   output logic [31:0] HRDATA
);

   localparam int unsigned Words   = DEPTH_IN_BYTES / 4;
   localparam int unsigned WordAw  = (Words > 1) ? $clog2(Words) : 1;
   localparam bit          HasWait = (WAIT_CYCLES != 0);
   localparam logic [3:0]  WaitLoad = HasWait ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_e              state_q;
   logic [3:0]          wait_cnt_q;
   logic [WordAw-1:0]   word_addr_q;
   logic [1:0]          lane_q;
   logic [2:0]          size_q;
   logic                write_q;
   logic                legal_q;
   logic                hready_q;
   logic [1:0]          hresp_q;

   logic [31:0]         offset;
   logic                accept;
   logic                in_range;
   logic                legal;
   state_e              accept_state;

   logic [3:0]          byte_en;
   logic                commit;
   logic [3:0]          ram_we;
   logic [31:0]         ram_rdata;

   // Burst type is informational only.
   logic unused_hburst;
   assign unused_hburst = ^HBURST;

   // Address-phase decode: accept qualification, legality and the state it leads to.
   always_comb begin
      offset       = HADDR - START_ADDR;
      accept       = HSEL && HREADY &&
                     ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
      in_range     = (offset < DEPTH_IN_BYTES);
      legal        = in_range && (HSIZE <= HSIZE_WORD) && size_aligned(HSIZE, HADDR[1:0]);
      accept_state = ST_ERR1;
      if (legal) begin
         accept_state = HasWait ? ST_WAIT : ST_DATA;
      end
   end

   // Transfer FSM; HREADYOUT/HRESP are registered from the state being entered.
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= 4'd0;
         word_addr_q <= '0;
         lane_q      <= 2'b00;
         size_q      <= 3'd0;
         write_q     <= 1'b0;
         legal_q     <= 1'b0;
         hready_q    <= 1'b1;
         hresp_q     <= HRESP_OKAY;
      end else begin
         unique case (state_q)
            // These three states all sit at an HREADYOUT=1 boundary, so a new
            // address phase may be taken here (back-to-back pipelining).
            ST_IDLE, ST_DATA, ST_ERR2: begin
               if (accept) begin
                  state_q     <= accept_state;
                  wait_cnt_q  <= WaitLoad;
                  word_addr_q <= offset[WordAw+1:2];
                  lane_q      <= HADDR[1:0];
                  size_q      <= HSIZE;
                  write_q     <= HWRITE;
                  legal_q     <= legal;
                  hready_q    <= state_ready(accept_state);
                  hresp_q     <= state_resp(accept_state);
               end else begin
                  state_q  <= ST_IDLE;
                  legal_q  <= 1'b0;
                  hready_q <= 1'b1;
                  hresp_q  <= HRESP_OKAY;
               end
            end
            ST_WAIT: begin
               if (wait_cnt_q == 4'd0) begin
                  state_q  <= ST_DATA;
                  hready_q <= 1'b1;
                  hresp_q  <= HRESP_OKAY;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 4'd1;
               end
            end
            ST_ERR1: begin
               state_q  <= ST_ERR2;
               hready_q <= 1'b1;
               hresp_q  <= HRESP_ERROR;
            end
            default: begin
               state_q  <= ST_IDLE;
               hready_q <= 1'b1;
               hresp_q  <= HRESP_OKAY;
            end
         endcase
      end
   end

   // Little-endian byte enables for the registered transfer; commit only on the
   // completing data beat of a legal write, never while reset is asserted.
   always_comb begin
      byte_en = 4'b0000;
      case (size_q)
         HSIZE_BYTE: byte_en = 4'b0001 << lane_q;
         HSIZE_HALF: byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: byte_en = 4'b1111;
         default:    byte_en = 4'b0000;
      endcase
      commit = (state_q == ST_DATA) && write_q && legal_q && HRESETn;
      ram_we = commit ? byte_en : 4'b0000;
   end

   // Read and write share the registered word address. A read that directly
   // follows a write to the same word sees the committed data, because the
   // write lands at the edge that starts the read's data phase.
   ahb_mem_bytelane_ram #(
      .Words (Words),
      .AddrW (WordAw)
   ) u_ram (
      .clk_i   (HCLK),
      .we_i    (ram_we),
      .waddr_i (word_addr_q),
      .wdata_i (HWDATA),
      .raddr_i (word_addr_q),
      .rdata_o (ram_rdata)
   );

   assign HREADYOUT = hready_q;
   assign HRESP     = hresp_q;
   assign HRDATA    = ((state_q == ST_DATA) && !write_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Bench for ahb_mem_slave: two instances on a small decoded bus (zero-wait and
// three-wait), a pipelined AHB master and an in-order scoreboard fed from a
// byte-level reference memory.
module tb_ahb_mem_slave;
   import ahb_mem_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [31:0] hwdata;
   logic        sel;    // 0 selects the zero-wait slave, 1 the three-wait slave

   logic        ro0, ro1;
   logic [1:0]  rs0, rs1;
   logic [31:0] rd0, rd1;
   logic        hsel0, hsel1;
   logic        hready_bus;
   logic [1:0]  hresp_bus;
   logic [31:0] hrdata_bus;

   always #5 HCLK = ~HCLK;

   assign hsel0      = hsel & ~sel;
   assign hsel1      = hsel & sel;
   assign hready_bus = sel ? ro1 : ro0;
   assign hresp_bus  = sel ? rs1 : rs0;
   assign hrdata_bus = sel ? rd1 : rd0;

   ahb_mem_slave #(
      .START_ADDR     (32'h0),
      .DEPTH_IN_BYTES (32'h400),
      .WAIT_CYCLES    (0)
   ) u_dut0 (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (hsel0),
      .HADDR     (haddr),
      .HTRANS    (htrans),
      .HWRITE    (hwrite),
      .HSIZE     (hsize),
      .HBURST    (hburst),
      .HWDATA    (hwdata),
      .HREADY    (hready_bus),
      .HREADYOUT (ro0),
      .HRESP     (rs0),
      .HRDATA    (rd0)
   );

   ahb_mem_slave #(
      .START_ADDR     (32'h0),
      .DEPTH_IN_BYTES (32'h400),
      .WAIT_CYCLES    (3)
   ) u_dut1 (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (hsel1),
      .HADDR     (haddr),
      .HTRANS    (htrans),
      .HWRITE    (hwrite),
      .HSIZE     (hsize),
      .HBURST    (hburst),
      .HWDATA    (hwdata),
      .HREADY    (hready_bus),
      .HREADYOUT (ro1),
      .HRESP     (rs1),
      .HRDATA    (rd1)
   );

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [2:0]  size;
      logic [1:0]  trans;
      logic [2:0]  burst;
      logic [31:0] wdata;
      bit          err;
   } xfer_t;

   typedef struct {
      bit          write;
      bit          err;
      logic [31:0] rdata;
      int          waits;
   } exp_t;

   xfer_t       stim_q[$];
   exp_t        sb_q[$];
   logic [7:0]  ref_mem [0:1][0:1023];
   int          n_checks = 0;
   int          n_fail   = 0;
   string       phase    = "reset";

   xfer_t       cur_a;
   xfer_t       cur_d;
   bit          a_valid;
   bit          d_valid;
   int          low_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got=%h exp=%h", phase, tag, got, exp);
      end
   endtask

   function automatic bit lane_hit(input logic [2:0] size, input logic [1:0] a, input int i);
      case (size)
         3'd0:    return i == int'(a);
         3'd1:    return (i / 2) == int'(a[1]);
         default: return 1'b1;
      endcase
   endfunction

   task automatic add(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                      input logic [1:0] trans, input logic [2:0] burst,
                      input logic [31:0] wdata, input bit err);
      xfer_t x;
      x.addr  = addr;
      x.write = wr;
      x.size  = size;
      x.trans = trans;
      x.burst = burst;
      x.wdata = wdata;
      x.err   = err;
      stim_q.push_back(x);
   endtask

   // Expected result is fixed at accept time; writes update the model in bus order.
   task automatic push_expected(input xfer_t x);
      exp_t e;
      int   base;
      e.write = x.write;
      e.err   = x.err;
      e.waits = x.err ? 1 : (sel ? 3 : 0);
      e.rdata = 32'h0;
      base    = int'(x.addr & 32'h3FC);
      if (!x.err) begin
         if (x.write) begin
            for (int i = 0; i < 4; i++) begin
               if (lane_hit(x.size, x.addr[1:0], i)) ref_mem[sel][base + i] = x.wdata[8*i +: 8];
            end
         end else begin
            e.rdata = {ref_mem[sel][base + 3], ref_mem[sel][base + 2],
                       ref_mem[sel][base + 1], ref_mem[sel][base]};
         end
      end
      sb_q.push_back(e);
   endtask

   task automatic drive_bus();
      hsel = 1'b1;
      if (a_valid) begin
         haddr  = cur_a.addr;
         htrans = cur_a.trans;
         hwrite = cur_a.write;
         hsize  = cur_a.size;
         hburst = cur_a.burst;
      end else begin
         haddr  = 32'h0;
         htrans = HTRANS_IDLE;
         hwrite = 1'b0;
         hsize  = 3'd0;
         hburst = 3'd0;
      end
      hwdata = d_valid ? cur_d.wdata : 32'h0;
   endtask

   task automatic load_next();
      if (stim_q.size() != 0) begin
         cur_a   = stim_q.pop_front();
         a_valid = 1'b1;
      end else begin
         a_valid = 1'b0;
      end
   endtask

   task automatic complete_beat();
      exp_t e;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s/sb_underflow: got=beat exp=none", phase);
      end else begin
         e = sb_q.pop_front();
         check_eq("waits", low_cnt, e.waits);
         check_eq("resp", {30'b0, hresp_bus}, e.err ? 32'd1 : 32'd0);
         check_eq(e.write ? "rdata_on_write" : "rdata", hrdata_bus, e.rdata);
      end
   endtask

   // Pipelined master: address phase of the next transfer overlaps the data
   // phase of the current one; both advance only when the bus is ready.
   task automatic run_stim(input int max_cycles);
      bit rdy;
      int cyc;
      d_valid = 1'b0;
      low_cnt = 0;
      cyc     = 0;
      load_next();
      drive_bus();
      while ((a_valid || d_valid) && (cyc < max_cycles)) begin
         @(negedge HCLK);
         rdy = hready_bus;
         if (d_valid) begin
            if (!rdy) begin
               low_cnt++;
               if (sb_q.size() != 0) begin
                  check_eq("resp_stalled", {30'b0, hresp_bus}, sb_q[0].err ? 32'd1 : 32'd0);
               end
            end else begin
               complete_beat();
            end
         end
         @(posedge HCLK);
         #1;
         if (rdy) begin
            d_valid = a_valid && cur_a.trans[1];
            if (d_valid) begin
               cur_d = cur_a;
               push_expected(cur_a);
            end
            low_cnt = 0;
            load_next();
            drive_bus();
         end
         cyc++;
      end
      check_eq("drained", {30'b0, a_valid, d_valid}, 32'd0);
      check_eq("sb_empty", sb_q.size(), 32'd0);
      stim_q.delete();
      sb_q.delete();
      a_valid = 1'b0;
      d_valid = 1'b0;
      drive_bus();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sel     = 1'b0;
      HRESETn = 1'b0;
      a_valid = 1'b0;
      d_valid = 1'b0;
      drive_bus();
      hsel    = 1'b0;
      repeat (3) @(posedge HCLK);
      #1;
      check_eq("rst_ready0", {31'b0, ro0}, 32'd1);
      check_eq("rst_resp0", {30'b0, rs0}, 32'd0);
      check_eq("rst_rdata0", rd0, 32'h0);
      check_eq("rst_ready1", {31'b0, ro1}, 32'd1);
      check_eq("rst_resp1", {30'b0, rs1}, 32'd0);
      check_eq("rst_rdata1", rd1, 32'h0);
      HRESETn = 1'b1;
      @(posedge HCLK);
      #1;

      phase = "word_rw";
      add(32'h10, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'hDEADBEEF, 1'b0);
      add(32'h10, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'h0, 1'b0);
      run_stim(50);

      phase = "byte_half";
      add(32'h10, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'h11223344, 1'b0);
      add(32'h13, 1'b1, HSIZE_BYTE, HTRANS_NONSEQ, 3'd0, 32'hA5000000, 1'b0);
      add(32'h10, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'h0, 1'b0);
      add(32'h10, 1'b1, HSIZE_HALF, HTRANS_NONSEQ, 3'd0, 32'h00007777, 1'b0);
      add(32'h10, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'h0, 1'b0);
      add(32'h14, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'h00000000, 1'b0);
      add(32'h16, 1'b1, HSIZE_HALF, HTRANS_NONSEQ, 3'd0, 32'hBEEF0000, 1'b0);
      add(32'h15, 1'b1, HSIZE_BYTE, HTRANS_NONSEQ, 3'd0, 32'h00003C00, 1'b0);
      add(32'h14, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'h0, 1'b0);
      run_stim(80);

      phase = "burst_w0";
      for (int i = 0; i < 4; i++) begin
         add(32'h40 + 32'(4 * i), 1'b1, HSIZE_WORD, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
             3'b011, 32'h10000001 + 32'(i * 32'h01010101), 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         add(32'h40 + 32'(4 * i), 1'b0, HSIZE_WORD, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
             3'b011, 32'h0, 1'b0);
      end
      run_stim(80);

      phase = "errors";
      add(32'h0,   1'b1, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'h5A5A5A5A, 1'b0);
      add(32'h3FC, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'h0F0F0F0F, 1'b0);
      add(32'h400, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'h0, 1'b1);
      add(32'h0,   1'b0, 3'd0,       HTRANS_IDLE,   3'd0, 32'h0, 1'b0);
      add(32'h0,   1'b0, 3'd3,       HTRANS_NONSEQ, 3'd0, 32'h0, 1'b1);
      add(32'h0,   1'b0, 3'd0,       HTRANS_IDLE,   3'd0, 32'h0, 1'b0);
      add(32'h1,   1'b1, HSIZE_HALF, HTRANS_NONSEQ, 3'd0, 32'hFFFFFFFF, 1'b1);
      add(32'h0,   1'b0, 3'd0,       HTRANS_IDLE,   3'd0, 32'h0, 1'b0);
      add(32'h0,   1'b0, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'h0, 1'b0);
      add(32'h2,   1'b1, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'hFFFFFFFF, 1'b1);
      add(32'h0,   1'b0, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'h0, 1'b0);
      add(32'h3FC, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'h0, 1'b0);
      run_stim(100);

      phase  = "hsel_low";
      hsel   = 1'b0;
      haddr  = 32'h10;
      htrans = HTRANS_NONSEQ;
      hwrite = 1'b1;
      hsize  = HSIZE_WORD;
      hwdata = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge HCLK);
         check_eq("ready", {31'b0, hready_bus}, 32'd1);
         check_eq("resp", {30'b0, hresp_bus}, 32'd0);
         check_eq("rdata", hrdata_bus, 32'h0);
      end
      @(posedge HCLK);
      #1;
      htrans = HTRANS_IDLE;
      add(32'h10, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'h0, 1'b0);
      run_stim(20);

      sel = 1'b1;
      @(posedge HCLK);
      #1;

      phase = "wait3_single";
      add(32'h8, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'h8BADF00D, 1'b0);
      add(32'h8, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'h0, 1'b0);
      run_stim(50);

      phase = "wait3_burst";
      for (int i = 0; i < 4; i++) begin
         add(32'h40 + 32'(4 * i), 1'b1, HSIZE_WORD, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
             3'b011, 32'hC0DE0000 + 32'(i), 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         add(32'h40 + 32'(4 * i), 1'b0, HSIZE_WORD, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
             3'b011, 32'h0, 1'b0);
      end
      run_stim(120);

      phase = "reset_mid_wait";
      add(32'h20, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'hCAFEF00D, 1'b0);
      run_stim(30);
      hsel   = 1'b1;
      haddr  = 32'h20;
      htrans = HTRANS_NONSEQ;
      hwrite = 1'b1;
      hsize  = HSIZE_WORD;
      @(posedge HCLK);
      #1;
      htrans = HTRANS_IDLE;
      hwdata = 32'h0BADBEEF;
      @(negedge HCLK);
      check_eq("ready_in_wait", {31'b0, hready_bus}, 32'd0);
      HRESETn = 1'b0;
      @(posedge HCLK);
      #1;
      check_eq("ready_after_rst", {31'b0, hready_bus}, 32'd1);
      check_eq("resp_after_rst", {30'b0, hresp_bus}, 32'd0);
      check_eq("rdata_after_rst", hrdata_bus, 32'h0);
      HRESETn = 1'b1;
      repeat (6) @(posedge HCLK);
      #1;
      add(32'h20, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 3'd0, 32'h0, 1'b0);
      run_stim(30);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
